iter_alu: RTL and testbench
===========================

ITER_ALU -- requirements
Module: iter_alu

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand/result width in bits (legal range 4..64).
REQ-002 The block SHALL have port clk, input, 1, the single rising-edge clock.
REQ-003 The block SHALL have port reset, input, 1, an asynchronous active-low reset (0 = reset).
REQ-004 The block SHALL have port in_valid, input, 1, which qualifies op/a/b.
REQ-005 The block SHALL have port in_ready, output, 1, which is high only when a new operation can be accepted.
REQ-006 The block SHALL have port op, input, 3: 000 ADD, 001 SUB, 010 AND, 011 ORR, 111 EOR, 101 MUL, 110 UDIV; 100 is reserved.
REQ-007 The block SHALL have ports a and b, input, WIDTH, the operands.
REQ-008 The block SHALL have port out_valid, output, 1, a one-cycle pulse marking result/flags as new.
REQ-009 The block SHALL have port result, output, WIDTH, the registered result.
REQ-010 The block SHALL have port flags, output, 4, registered {N,Z,C,V}.

Function
REQ-011 Acceptance SHALL occur on a rising edge with in_valid=1 and in_ready=1; op/a/b SHALL be captured at that edge, and in_valid while in_ready=0 SHALL be ignored.
REQ-012 The FSM SHALL have states IDLE, MUL, DIV and DONE, with in_ready=1 only in IDLE.
REQ-013 In IDLE, accepting ADD/SUB/AND/ORR/EOR/reserved SHALL go to DONE; MUL SHALL go to MUL; UDIV SHALL go to DIV (with DIV_EN defined).
REQ-014 MUL SHALL be shift-add over WIDTH iteration cycles producing the low WIDTH bits of the unsigned product, then go to DONE.
REQ-015 UDIV SHALL be restoring division over WIDTH iteration cycles producing the unsigned quotient, then go to DONE.
REQ-016 DONE SHALL last exactly one cycle, with out_valid=1, result/flags updated, and a return to IDLE.
REQ-017 Latency from the accepting edge to the out_valid cycle SHALL be 1 cycle for single-cycle ops and WIDTH+1 cycles for MUL/UDIV.
REQ-018 ADD/SUB SHALL produce the WIDTH-bit sum; SUB SHALL compute a+~b+1; C SHALL be the carry out (SUB: 1 = no borrow); V SHALL be signed overflow.
REQ-019 Logic ops, MUL and the reserved op SHALL set C=0 and V=0; the reserved op SHALL give result 0.
REQ-020 For all ops, N SHALL equal result[WIDTH-1] and Z SHALL equal (result==0).
REQ-021 UDIV with b=0 SHALL give result all-ones with C=0 and V=1, at normal latency; otherwise C=V=0.
REQ-022 result/flags SHALL hold their values between out_valid pulses, and iteration registers SHALL NOT be visible on result.
REQ-023 No new op SHALL be accepted in the out_valid cycle; the earliest next acceptance SHALL be the following cycle.

Reset
REQ-024 When reset=0, the block SHALL asynchronously force the FSM to IDLE, result=0, flags=0000, out_valid=0 and the iteration counter to 0; in_ready SHALL read 1.
REQ-025 Reset mid-MUL/DIV SHALL abort the operation and produce no out_valid pulse for it.

Configuration
REQ-026 Macro ITER_ALU_DIV_EN: when defined, UDIV (op 110) and the DIV state SHALL be implemented.
REQ-027 When ITER_ALU_DIV_EN is undefined, no divider logic SHALL be present and op 110 SHALL behave as the reserved op (result 0, flags 0100, latency 1).

Verification
REQ-028 WIDTH=32, ADD 0x7FFFFFFF+0x00000001 -> result 0x80000000, flags 1001, out_valid 1 cycle after acceptance.
REQ-029 SUB 5-5 -> result 0, flags 0110; SUB 0-1 -> 0xFFFFFFFF, flags 1000.
REQ-030 MUL 0xFFFFFFFF*3 -> result 0xFFFFFFFD, flags 1000, out_valid exactly 33 cycles after acceptance; in_ready=0 throughout, and in_valid pulses in between are ignored.
REQ-031 With DIV_EN, UDIV 100/7 -> result 14, flags 0000, latency 33; UDIV 9/0 -> 0xFFFFFFFF, flags 1001. Without DIV_EN, op 110 -> result 0, flags 0100, latency 1.
REQ-032 Reset=0 on the 10th MUL iteration -> out_valid stays 0, result 0, in_ready=1; after release, ADD 2+3 -> result 5 one cycle later.
REQ-033 WIDTH=8, MUL 0x10*0x10 -> result 0x00, flags 0100, latency 9; back-to-back single-cycle ops accepted every 2 cycles.

Source files
------------

// File: rtl/iter_alu.sv
// iter_alu: iterative ALU with single-cycle ADD/SUB/AND/ORR/EOR, shift-add MUL and (ITER_ALU_DIV_EN) restoring UDIV.
// Latency: 1 cycle from the accepting edge to out_valid for single-cycle ops, WIDTH+1 cycles for MUL/UDIV.
// Backpressure: in_ready is high only in IDLE; in_valid while busy or in the out_valid cycle is ignored.
`timescale 1ns/1ps
module iter_alu #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   output logic [WIDTH-1:0] result,
   output logic [3:0]       flags
);

   localparam int CW = $clog2(WIDTH) + 1;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_ORR = 3'b011;
   localparam logic [2:0] OP_EOR = 3'b111;
   localparam logic [2:0] OP_MUL = 3'b101;
`ifdef ITER_ALU_DIV_EN
   localparam logic [2:0] OP_DIV = 3'b110;
`endif

   typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   // acc: product accumulator (MUL) / partial remainder (DIV)
   logic [WIDTH-1:0] acc_q, acc_d;
   // opa: multiplier shifted right (MUL) / dividend shifted out, quotient shifted in (DIV)
   logic [WIDTH-1:0] opa_q, opa_d;
   // opb: multiplicand shifted left (MUL) / divisor held (DIV)
   logic [WIDTH-1:0] opb_q, opb_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic [3:0]       flags_q, flags_d;

   logic [WIDTH:0]   sum_add, sum_sub;
   logic [WIDTH-1:0] res_c;
   logic             c_c, v_c, load;
   logic             last_iter;

   assign sum_add   = {1'b0, a} + {1'b0, b};
   assign sum_sub   = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
   assign last_iter = (cnt_q == CW'(WIDTH - 1));

`ifdef ITER_ALU_DIV_EN
   // One restoring step: bring down the next dividend bit and try to subtract the divisor.
   logic [WIDTH:0] div_shift, div_diff;
   logic           div_ge;
   assign div_shift = {acc_q, opa_q[WIDTH-1]};
   assign div_diff  = div_shift - {1'b0, opb_q};
   assign div_ge    = (div_shift >= {1'b0, opb_q});
`endif

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign result    = result_q;
   assign flags     = flags_q;

   // Next-state, iteration datapath and result/flag load.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      opa_d    = opa_q;
      opb_d    = opb_q;
      result_d = result_q;
      flags_d  = flags_q;
      res_c    = '0;
      c_c      = 1'b0;
      v_c      = 1'b0;
      load     = 1'b0;

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               cnt_d = '0;
               case (op)
                  OP_MUL: begin
                     state_d = MUL;
                     acc_d   = '0;
                     opa_d   = b;
                     opb_d   = a;
                  end
`ifdef ITER_ALU_DIV_EN
                  OP_DIV: begin
                     state_d = DIV;
                     acc_d   = '0;
                     opa_d   = a;
                     opb_d   = b;
                  end
`endif
                  default: begin
                     state_d = DONE;
                     load    = 1'b1;
                     case (op)
                        OP_ADD: begin
                           res_c = sum_add[WIDTH-1:0];
                           c_c   = sum_add[WIDTH];
                           v_c   = (a[WIDTH-1] == b[WIDTH-1]) && (sum_add[WIDTH-1] != a[WIDTH-1]);
                        end
                        OP_SUB: begin
                           res_c = sum_sub[WIDTH-1:0];
                           c_c   = sum_sub[WIDTH];
                           v_c   = (a[WIDTH-1] != b[WIDTH-1]) && (sum_sub[WIDTH-1] != a[WIDTH-1]);
                        end
                        OP_AND:  res_c = a & b;
                        OP_ORR:  res_c = a | b;
                        OP_EOR:  res_c = a ^ b;
                        default: res_c = '0;
                     endcase
                  end
               endcase
            end
         end
         MUL: begin
            acc_d = opa_q[0] ? (acc_q + opb_q) : acc_q;
            opb_d = opb_q << 1;
            opa_d = opa_q >> 1;
            cnt_d = cnt_q + 1'b1;
            if (last_iter) begin
               state_d = DONE;
               load    = 1'b1;
               res_c   = acc_d;
            end
         end
`ifdef ITER_ALU_DIV_EN
         DIV: begin
            acc_d = div_ge ? WIDTH'(div_diff) : WIDTH'(div_shift);
            opa_d = {opa_q[WIDTH-2:0], div_ge};
            cnt_d = cnt_q + 1'b1;
            if (last_iter) begin
               state_d = DONE;
               load    = 1'b1;
               res_c   = opa_d;
               // Divide by zero naturally yields all-ones; flag it as overflow.
               v_c     = (opb_q == '0);
            end
         end
`endif
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      if (load) begin
         result_d = res_c;
         flags_d  = {res_c[WIDTH-1], (res_c == '0), c_c, v_c};
      end
   end

   // State and datapath registers; reset aborts any operation in flight.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         acc_q    <= '0;
         opa_q    <= '0;
         opb_q    <= '0;
         result_q <= '0;
         flags_q  <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         opa_q    <= opa_d;
         opb_q    <= opb_d;
         result_q <= result_d;
         flags_q  <= flags_d;
      end
   end

endmodule

// File: tb/tb_iter_alu.sv
// Self-checking bench for iter_alu: directed vector table, multi-cycle corner sequences,
// and randomized ops compared against an arithmetic reference model (WIDTH=32 and WIDTH=8 instances).
`timescale 1ns/1ps
module tb_iter_alu;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        in_valid, in_ready, out_valid;
   logic [2:0]  op;
   logic [31:0] a, b, result;
   logic [3:0]  flags;

   logic        v8, rdy8, ov8;
   logic [2:0]  op8;
   logic [7:0]  a8, b8, res8;
   logic [3:0]  flg8;

   int total = 0;
   int bad   = 0;

   iter_alu #(.WIDTH(32)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .op(op),
      .a(a), .b(b), .out_valid(out_valid), .result(result), .flags(flags)
   );

   iter_alu #(.WIDTH(8)) dut8 (
      .clk(clk), .reset(reset), .in_valid(v8), .in_ready(rdy8), .op(op8),
      .a(a8), .b(b8), .out_valid(ov8), .result(res8), .flags(flg8)
   );

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] r;
      logic [3:0]  f;
      int          lat;
   } vec_t;

   vec_t tbl[$];

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Reference: results straight from integer arithmetic on the operands.
   function automatic void model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                 output logic [31:0] r, output logic [3:0] f, output int lat);
      longint unsigned s;
      longint          sr;
      logic            c, v;
      c = 1'b0; v = 1'b0; lat = 1; r = '0;
      case (o)
         3'b000: begin
            s  = {32'b0, x} + {32'b0, y};
            r  = s[31:0];
            c  = (s >= 64'h1_0000_0000);
            sr = longint'($signed(x)) + longint'($signed(y));
            v  = (sr != longint'($signed(r)));
         end
         3'b001: begin
            r  = x - y;
            c  = (x >= y);
            sr = longint'($signed(x)) - longint'($signed(y));
            v  = (sr != longint'($signed(r)));
         end
         3'b010: r = x & y;
         3'b011: r = x | y;
         3'b111: r = x ^ y;
         3'b101: begin
            s   = {32'b0, x} * {32'b0, y};
            r   = s[31:0];
            lat = 33;
         end
`ifdef ITER_ALU_DIV_EN
         3'b110: begin
            lat = 33;
            if (y == 0) begin r = 32'hFFFF_FFFF; v = 1'b1; end
            else r = x / y;
         end
`endif
         default: r = '0;
      endcase
      f = {r[31], (r == 0), c, v};
   endfunction

   // Issue one op on the 32-bit instance (called at a negedge in IDLE) and check everything about it.
   task automatic exec32(input string nm, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         input bit noise, input logic [31:0] er, input logic [3:0] ef, input int el);
      int          lat, busy;
      logic [31:0] r;
      logic [3:0]  f;
      check({nm, " ready_before"}, in_ready, 1);
      op = o; a = x; b = y; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      busy = 0; lat = 1;
      @(negedge clk);
      while (!out_valid && lat < 100) begin
         if (in_ready) busy++;
         if (noise) begin
            in_valid = 1'b1; op = 3'($urandom_range(0, 7)); a = $urandom; b = $urandom;
         end
         @(negedge clk);
         lat++;
      end
      in_valid = 1'b0;
      r = result; f = flags;
      check({nm, " result"}, r, er);
      check({nm, " flags"}, f, ef);
      check({nm, " latency"}, lat, el);
      check({nm, " ready_while_busy"}, busy, 0);
      @(negedge clk);
      check({nm, " pulse_end"}, {out_valid, in_ready}, 2'b01);
      check({nm, " result_hold"}, result, er);
   endtask

   task automatic exec8(input string nm, input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                        input logic [7:0] er, input logic [3:0] ef, input int el);
      int lat;
      op8 = o; a8 = x; b8 = y; v8 = 1'b1;
      @(posedge clk); #1;
      v8 = 1'b0;
      lat = 1;
      @(negedge clk);
      while (!ov8 && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      check({nm, " result"}, res8, er);
      check({nm, " flags"}, flg8, ef);
      check({nm, " latency"}, lat, el);
      @(negedge clk);
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [31:0] er, x, y;
      logic [3:0]  ef;
      int          el, pulses, spurious;
      logic [2:0]  o;

      reset = 1'b0; in_valid = 1'b0; op = '0; a = '0; b = '0;
      v8 = 1'b0; op8 = '0; a8 = '0; b8 = '0;

      tbl.push_back('{3'b000, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 4'b1001, 1});
      tbl.push_back('{3'b001, 32'd5,         32'd5,         32'h0000_0000, 4'b0110, 1});
      tbl.push_back('{3'b001, 32'd0,         32'd1,         32'hFFFF_FFFF, 4'b1000, 1});
      tbl.push_back('{3'b000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 4'b0110, 1});
      tbl.push_back('{3'b001, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 4'b0011, 1});
      tbl.push_back('{3'b010, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 4'b1000, 1});
      tbl.push_back('{3'b011, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 4'b0100, 1});
      tbl.push_back('{3'b111, 32'h0000_000F, 32'h0000_00F0, 32'h0000_00FF, 4'b0000, 1});
      tbl.push_back('{3'b100, 32'h0000_0005, 32'h0000_0003, 32'h0000_0000, 4'b0100, 1});
      tbl.push_back('{3'b101, 32'hFFFF_FFFF, 32'h0000_0003, 32'hFFFF_FFFD, 4'b1000, 33});
      tbl.push_back('{3'b101, 32'h0000_0000, 32'h0000_0005, 32'h0000_0000, 4'b0100, 33});
`ifdef ITER_ALU_DIV_EN
      tbl.push_back('{3'b110, 32'd100,       32'd7,         32'd14,        4'b0000, 33});
      tbl.push_back('{3'b110, 32'd9,         32'd0,         32'hFFFF_FFFF, 4'b1001, 33});
`else
      tbl.push_back('{3'b110, 32'd100,       32'd7,         32'h0000_0000, 4'b0100, 1});
`endif

      // Reset state
      #12;
      check("reset in_ready", in_ready, 1);
      check("reset out_valid", out_valid, 0);
      check("reset result", result, 0);
      check("reset flags", flags, 0);
      check("reset8 in_ready", rdy8, 1);
      check("reset8 result", res8, 0);
      @(negedge clk); @(negedge clk);
      reset = 1'b1;
      @(negedge clk);

      // Directed table; MUL rows get in_valid noise while busy
      foreach (tbl[i])
         exec32($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, (tbl[i].op == 3'b101),
                tbl[i].r, tbl[i].f, tbl[i].lat);

      // Back-to-back single-cycle ops: in_valid held high gives one result every 2 cycles
      op = 3'b000; a = 32'd1; b = 32'd1; in_valid = 1'b1;
      pulses = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (out_valid) pulses++;
      end
      in_valid = 1'b0;
      check("b2b pulses", pulses, 3);
      check("b2b result", result, 2);
      @(negedge clk);

      // Reset during the 10th MUL iteration aborts it
      op = 3'b101; a = 32'd123; b = 32'd456; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (9) @(negedge clk);
      reset = 1'b0;
      #1;
      check("abort in_ready", in_ready, 1);
      check("abort out_valid", out_valid, 0);
      check("abort result", result, 0);
      check("abort flags", flags, 0);
      @(negedge clk);
      reset = 1'b1;
      spurious = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (out_valid) spurious++;
      end
      check("abort no pulse", spurious, 0);
      exec32("post_reset add", 3'b000, 32'd2, 32'd3, 1'b0, 32'd5, 4'b0000, 1);

      // WIDTH=8 instance
      exec8("w8 mul", 3'b101, 8'h10, 8'h10, 8'h00, 4'b0100, 9);
      exec8("w8 mul2", 3'b101, 8'h0D, 8'h0B, 8'h8F, 4'b1000, 9);
      exec8("w8 add", 3'b000, 8'h7F, 8'h01, 8'h80, 4'b1001, 1);

      // Randomized ops against the reference model
      for (int k = 0; k < 60; k++) begin
         o = 3'($urandom_range(0, 7));
         x = $urandom;
         y = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
         if (k % 7 == 0) x = y;
         model(o, x, y, er, ef, el);
         exec32($sformatf("rand%0d op%0d", k, o), o, x, y, (k % 3 == 0), er, ef, el);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
